// File: rtl/uart_pkg.sv
// Shared encodings and constants for the buffered UART.
package uart_pkg;

  // Parity mode as carried on cfg_parity; 2'b11 behaves like none.
  typedef enum logic [1:0] {
    PARITY_NONE     = 2'b00,
    PARITY_EVEN     = 2'b01,
    PARITY_ODD      = 2'b10,
    PARITY_NONE_ALT = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Smallest usable clocks-per-bit; smaller non-zero divisors are clamped up.
  localparam int MIN_DIVISOR = 4;

  // True when the mode carries a parity bit on the line.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-stream handshake bundle: TX FIFO write port and RX FIFO read port.
interface uart_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;

  // User side: produces bytes to send, consumes received bytes.
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  // UART side.
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible
// on pop_data. Pointers carry one extra wrap bit to separate full from empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on empty is ignored (no bypass); a push on full is only taken
  // when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update, wrapping naturally through the extra bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_buffered.sv
// UART with TX and RX FIFOs, runtime divisor/parity/stop configuration
// latched per frame, and single-cycle receive error pulses.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DIV_WIDTH-1:0]        cfg_divisor,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  uart_if.slave                       bus,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err,
  output logic                        rx_overrun,
  input  logic                        serial_in,
  output logic                        serial_out
);
  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(CLOCK_FREQ / BAUD_RATE);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV     = DIV_WIDTH'(MIN_DIVISOR);
  localparam logic [DIV_WIDTH-1:0] ONE         = DIV_WIDTH'(1);
  localparam logic [3:0]           LAST_DATA   = 4'(DATA_BITS - 1);

  // ---------------------------------------------------------------- config
  logic [DIV_WIDTH-1:0] eff_div;

  // Effective clocks-per-bit: 0 picks the parameter rate, tiny values clamp.
  always_comb begin
    eff_div = cfg_divisor;
    if (cfg_divisor == '0)          eff_div = DEFAULT_DIV;
    else if (cfg_divisor < MIN_DIV) eff_div = MIN_DIV;
  end

  // Holds data_in_ready low until the first edge after reset release.
  logic ready_en;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // ----------------------------------------------------------------- FIFOs
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty, rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_shift;

  assign bus.data_in_ready  = ready_en && !tx_full;
  assign tx_push            = bus.data_in_valid && bus.data_in_ready;
  assign bus.data_out_valid = !rx_empty;
  assign rx_pop             = bus.data_out_valid && bus.data_out_ready;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tx_push),
    .push_data (bus.data_in),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .pop_data  (bus.data_out),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  // -------------------------------------------------------------------- TX
  tx_state_t            tx_state, tx_state_next;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
  logic [3:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par_bit, tx_par_en, tx_stop2;
  logic                 tx_tick, tx_data_last, tx_stop_last, tx_line;

  assign tx_tick      = (tx_cnt == tx_div - ONE);
  assign tx_data_last = (tx_idx == LAST_DATA);
  assign tx_stop_last = (tx_idx == {3'b000, tx_stop2});

  // TX state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_state_next;
  end

  // TX next state; the last stop bit chains straight into the next start.
  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) tx_state_next = TX_START;
      TX_START:  if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA:   if (tx_tick && tx_data_last) tx_state_next = tx_par_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_state_next = TX_STOP;
      TX_STOP:   if (tx_tick && tx_stop_last) tx_state_next = tx_empty ? TX_IDLE : TX_START;
      default:   tx_state_next = TX_IDLE;
    endcase
  end

  // TX outputs: line level for the current bit and FIFO pop at frame start.
  always_comb begin
    tx_line = 1'b1;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:   tx_pop  = !tx_empty;
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift[0];
      TX_PARITY: tx_line = tx_par_bit;
      TX_STOP:   tx_pop  = tx_tick && tx_stop_last && !tx_empty;
      default:   tx_line = 1'b1;
    endcase
  end

  // TX datapath: latch byte and config on pop, then bit timing and shifting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt     <= '0;
      tx_div     <= MIN_DIV;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_par_bit <= 1'b0;
      tx_par_en  <= 1'b0;
      tx_stop2   <= 1'b0;
    end else if (tx_pop) begin
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_div     <= eff_div;
      tx_shift   <= tx_head;
      tx_par_en  <= parity_enabled(cfg_parity);
      tx_stop2   <= cfg_stop2;
      tx_par_bit <= (cfg_parity == PARITY_ODD) ? ~^tx_head : ^tx_head;
    end else if (tx_state != TX_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        tx_idx <= (tx_state_next != tx_state) ? 4'd0 : tx_idx + 4'd1;
        if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
      end else begin
        tx_cnt <= tx_cnt + ONE;
      end
    end
  end

  // Registered line driver; reset forces it high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) serial_out <= 1'b1;
    else          serial_out <= tx_line;
  end

  // -------------------------------------------------------------------- RX
  logic [1:0] rx_sync;
  logic       rx_bit, rx_prev, rx_fall;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], serial_in};
      rx_prev <= rx_sync[1];
    end
  end

  // A start needs a genuine high-to-low transition, so after a low stop bit
  // the receiver stays idle until the line has returned high.
  assign rx_bit  = rx_sync[1];
  assign rx_fall = rx_prev && !rx_bit;

  rx_state_t            rx_state, rx_state_next;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_div;
  logic [3:0]           rx_idx;
  logic                 rx_par_en, rx_par_odd, rx_par_bit, rx_par_exp, rx_tick;
  logic                 frame_err_next, parity_err_next, overrun_next;

  // The start bit is checked at mid-bit; every later sample is one bit later.
  assign rx_tick    = (rx_state == RX_START) ? (rx_cnt == (rx_div >> 1) - ONE)
                                             : (rx_cnt == rx_div - ONE);
  assign rx_par_exp = rx_par_odd ? ~^rx_shift : ^rx_shift;

  // RX state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_state_next;
  end

  // RX next state; a high mid-start sample is a false start.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_state_next = RX_START;
      RX_START:  if (rx_tick) rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && rx_idx == LAST_DATA) rx_state_next = rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_state_next = RX_STOP;
      RX_STOP:   if (rx_tick) rx_state_next = RX_IDLE;
      default:   rx_state_next = RX_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict, either a FIFO push or exactly one error.
  always_comb begin
    rx_push         = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    overrun_next    = 1'b0;
    if (rx_state == RX_STOP && rx_tick) begin
      if (!rx_bit)                                frame_err_next  = 1'b1;
      else if (rx_par_en && rx_par_bit != rx_par_exp) parity_err_next = 1'b1;
      else if (rx_full && !rx_pop)                overrun_next    = 1'b1;
      else                                        rx_push         = 1'b1;
    end
  end

  // RX datapath: latch config at the start edge, sample and shift LSB first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt     <= '0;
      rx_div     <= MIN_DIV;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bit <= 1'b0;
    end else if (rx_state == RX_IDLE) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      if (rx_fall) begin
        rx_div     <= eff_div;
        rx_par_en  <= parity_enabled(cfg_parity);
        rx_par_odd <= (cfg_parity == PARITY_ODD);
      end
    end else if (rx_tick) begin
      rx_cnt <= '0;
      rx_idx <= (rx_state_next != rx_state) ? 4'd0 : rx_idx + 4'd1;
      if (rx_state == RX_DATA)   rx_shift   <= {rx_bit, rx_shift[DATA_BITS-1:1]};
      if (rx_state == RX_PARITY) rx_par_bit <= rx_bit;
    end else begin
      rx_cnt <= rx_cnt + ONE;
    end
  end

  // Error outputs registered as one-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err  <= frame_err_next;
      rx_parity_err <= parity_err_next;
      rx_overrun    <= overrun_next;
    end
  end
endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 Parameter CLOCK_FREQ, default 100_000_000, shall be the clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 1_000_000, shall set the bit period used when cfg_divisor is 0.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9, shall be the payload bits per frame.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two and at least 2, shall be the entry count of each of the TX and RX FIFOs.
REQ-005 Parameter DIV_WIDTH, default 16, shall be the width of cfg_divisor.
REQ-006 clk  in  1  single clock; all logic shall be on its rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 cfg_divisor  in  DIV_WIDTH  clocks per bit; 0 selects CLOCK_FREQ/BAUD_RATE; values 1..3 behave as 4.
REQ-009 cfg_parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-010 cfg_stop2  in  1  1 selects two TX stop bits; RX always checks one stop bit.
REQ-011 data_in / data_in_valid / data_in_ready  in/in/out  DATA_BITS/1/1  TX FIFO write port.
REQ-012 data_out / data_out_valid / data_out_ready  out/out/in  DATA_BITS/1/1  RX FIFO read port.
REQ-013 tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 rx_parity_err, rx_frame_err, rx_overrun  out  1  single-cycle error pulses.
REQ-015 serial_in  in  1  asynchronous line input; serial_out  out  1  registered line output, idle high.

Function
REQ-016 A transfer shall occur on any cycle where valid and ready are both high; data_in_ready = TX FIFO not full; data_out_valid = RX FIFO not empty; data_out shall show the RX FIFO head.
REQ-017 cfg_divisor, cfg_parity and cfg_stop2 shall be captured at each frame start and held for the whole frame.
REQ-018 The TX FSM shall use states IDLE, START, DATA, PARITY, STOP; each state shall last one bit period; DATA shall send LSB first; PARITY shall be skipped when parity is none; STOP shall last 1 or 2 bit periods.
REQ-019 In IDLE with the TX FIFO non-empty, the TX FSM shall pop one entry, and serial_out shall go low no later than 3 clk cycles after the data_in handshake.
REQ-020 Back-to-back frames shall have no idle gap beyond the stop bits.
REQ-021 serial_in shall pass a 2-flop synchroniser; the RX FSM shall use states IDLE, START, DATA, PARITY, STOP.
REQ-022 The RX FSM shall leave IDLE on a synchronised high-to-low edge and sample at half a bit period; a high sample there shall be a false start and shall return it to IDLE.
REQ-023 All later RX samples shall be taken at bit centres, one divisor apart.
REQ-024 At stop-bit sample: a low stop bit shall pulse rx_frame_err; a parity mismatch shall pulse rx_parity_err; in both cases the byte shall be discarded.
REQ-025 At stop-bit sample, a valid byte arriving with the RX FIFO full shall pulse rx_overrun and be discarded; FIFO contents shall be unchanged.
REQ-026 After a frame error, the RX FSM shall wait for serial_in high before re-arming in IDLE.
REQ-027 A simultaneous push and pop on a full or empty FIFO shall be legal: on full, the pop frees the slot; on empty, no bypass; level shall be unchanged when both occur on a non-empty, non-full FIFO.
REQ-028 FIFO pointers shall wrap modulo FIFO_DEPTH using one extra bit to tell full from empty.

Reset
REQ-029 While reset_n is low, outputs shall be: serial_out=1, data_in_ready=0, data_out_valid=0, both levels=0, error pulses=0, both FSMs in IDLE, and FIFOs empty.
REQ-030 Reset asserted mid-frame shall abort the frame immediately; serial_out shall return high asynchronously.
REQ-031 data_in_ready shall rise on the first clk edge after reset_n deasserts.

Structure
REQ-032 Package uart_pkg shall hold the parity-mode encoding, the TX and RX FSM state encodings, and the minimum-divisor constant (4).
REQ-033 One sub-module, uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), shall be instantiated twice.
REQ-034 TX and RX datapaths shall be inline in uart_buffered.

Verification
REQ-035 Loopback test: divisor 100, parity none, push 0xA5 -> 0xA5 appears on data_out after about 1000 cycles; no error pulses.
REQ-036 TX framing test: parity even, stop2=1, push 0x07 -> line shows 0,1,1,1,0,0,0,0,0,P=1,1,1 with each bit 100 cycles.
REQ-037 Parity error test: drive a frame with a wrong parity bit -> exactly one rx_parity_err pulse; rx_level stays 0.
REQ-038 Overrun test: FIFO_DEPTH=4, deliver 5 frames with data_out_ready=0 -> rx_level=4, one rx_overrun pulse, and the first 4 bytes read back in order.
REQ-039 Glitch and frame-error test: a 30-cycle low glitch is ignored as a false start; a frame with a low stop bit gives rx_frame_err and no push.
REQ-040 Reset test: assert reset_n mid-frame at cycle 450 -> serial_out high immediately; tx_level=0; the next push transmits a clean frame.
